// File: rtl/lightsout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lightsout_pkg
// Purpose  : Shared PS/2 scancode constants, frame receiver and scancode
//            decoder state encodings, and a parity helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lightsout_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        FR_IDLE   = 2'd0,
        FR_DATA   = 2'd1,
        FR_PARITY = 2'd2,
        FR_STOP   = 2'd3
    } frame_state_t;

    typedef enum logic [1:0] {
        DEC_NORMAL    = 2'd0,
        DEC_EXT       = 2'd1,
        DEC_BREAK     = 2'd2,
        DEC_EXT_BREAK = 2'd3
    } dec_state_t;

    // PS/2 uses odd parity over the 8 data bits plus the parity bit.
    function automatic logic f_odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_frame_rx
// Purpose  : PS/2 device-to-host frame receiver. Synchronizes the raw lines,
//            glitch-filters ps2_clk, and assembles 11-bit frames
//            (start, 8 data LSB first, odd parity, stop) with an inter-bit
//            timeout.
// Ports    : clk, reset (sync, active-low)
//            i_ps2_clk, i_ps2_dat  raw asynchronous PS/2 lines
//            o_byte                last good byte
//            o_byte_valid          one-cycle strobe, o_byte valid
//            o_frame_err           one-cycle pulse on a discarded frame
// Revision : 1.0 - initial release
// ============================================================================
module ps2_frame_rx
    import lightsout_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          r_clk_s1, r_clk_s2;
    logic          r_dat_s1, r_dat_s2;
    logic          r_level;
    logic [FW-1:0] r_filt_cnt;
    logic          w_accept;
    logic          w_fall;

    frame_state_t  r_state, w_next;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_byte;
    logic          r_valid;
    logic          r_err;
    logic          w_good;
    logic          w_bad;
    logic          w_timeout;

    // Lines idle high, so the synchronizers reset to 1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_dat;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // A new ps2_clk level is accepted on its FILTER_LEN-th consecutive sample.
    assign w_accept = (r_clk_s2 != r_level) && (r_filt_cnt == FW'(FILTER_LEN - 1));
    assign w_fall   = w_accept && r_level;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_level    <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_s2 == r_level) begin
            r_filt_cnt <= '0;
        end else if (w_accept) begin
            r_level    <= r_clk_s2;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= FR_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_good    = 1'b0;
        w_bad     = 1'b0;
        w_timeout = (r_state != FR_IDLE) && !w_fall &&
                    (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
        case (r_state)
            FR_IDLE: begin
                // A start bit of 1 is not a frame; stay idle silently.
                if (w_fall && !r_dat_s2) begin
                    w_next = FR_DATA;
                end
            end
            FR_DATA: begin
                if (w_fall && (r_bit_cnt == 3'd7)) begin
                    w_next = FR_PARITY;
                end
            end
            FR_PARITY: begin
                if (w_fall) begin
                    w_next = FR_STOP;
                end
            end
            FR_STOP: begin
                if (w_fall) begin
                    w_next = FR_IDLE;
                    if (r_dat_s2 && f_odd_parity_ok(r_shift, r_par)) begin
                        w_good = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            default: w_next = FR_IDLE;
        endcase
        if (w_timeout) begin
            w_next = FR_IDLE;
            w_bad  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_to_cnt  <= '0;
            r_byte    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid <= w_good;
            r_err   <= w_bad;
            if (w_good) begin
                r_byte <= r_shift;
            end
            // Timeout counts idle cycles since the last accepted edge.
            if ((r_state == FR_IDLE) || w_fall || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_fall) begin
                case (r_state)
                    FR_IDLE:   r_bit_cnt <= '0;
                    FR_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    FR_PARITY: r_par <= r_dat_s2;
                    default:   r_par <= r_par;
                endcase
            end
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_valid;
    assign o_frame_err  = r_err;

endmodule
`default_nettype wire

// File: rtl/ps2_cursor_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_cursor_decoder
// Purpose  : Turns PS/2 keyboard arrow/Enter releases into a cursor position
//            on a DIM x DIM board plus a selection handshake.
//            Optional macro CURSOR_WRAP_EN: cursor moves wrap modulo DIM
//            (default: saturate at 0 and DIM-1).
// Ports    : clk, reset (sync, active-low)
//            ps2_clk, ps2_dat   raw PS/2 lines
//            sel_ack            consumer accepts pending selection
//            x_input, y_input   cursor column/row
//            sel_valid          selection pending
//            frame_err          one-cycle pulse on a discarded frame
// Revision : 1.0 - initial release
// ============================================================================
module ps2_cursor_decoder
    import lightsout_pkg::*;
#(
    parameter int DIM            = 32,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       sel_ack,
    output logic [4:0] x_input,
    output logic [4:0] y_input,
    output logic       sel_valid,
    output logic       frame_err
);

    localparam logic [4:0] c_max = 5'(DIM - 1);

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_frame_err;

    dec_state_t r_dec, w_dec_next;
    logic       w_up, w_down, w_left, w_right, w_enter;
    logic [4:0] r_x, r_y;
    logic       r_sel;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_dat    (ps2_dat),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err)
    );

    function automatic logic [4:0] f_dec(input logic [4:0] v);
`ifdef CURSOR_WRAP_EN
        return (v == 5'd0) ? c_max : v - 5'd1;
`else
        return (v == 5'd0) ? 5'd0 : v - 5'd1;
`endif
    endfunction

    function automatic logic [4:0] f_inc(input logic [4:0] v);
`ifdef CURSOR_WRAP_EN
        return (v >= c_max) ? 5'd0 : v + 5'd1;
`else
        return (v >= c_max) ? c_max : v + 5'd1;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dec <= DEC_NORMAL;
        end else begin
            r_dec <= w_dec_next;
        end
    end

    // Only releases (a byte following 0xF0) generate actions; Enter is
    // honoured only without the 0xE0 prefix.
    always_comb begin
        w_dec_next = r_dec;
        w_up       = 1'b0;
        w_down     = 1'b0;
        w_left     = 1'b0;
        w_right    = 1'b0;
        w_enter    = 1'b0;
        if (w_frame_err) begin
            w_dec_next = DEC_NORMAL;
        end else if (w_byte_valid) begin
            case (w_byte)
                SC_EXT:   w_dec_next = DEC_EXT;
                SC_BREAK: w_dec_next = (r_dec == DEC_EXT) ? DEC_EXT_BREAK : DEC_BREAK;
                default: begin
                    w_dec_next = DEC_NORMAL;
                    if ((r_dec == DEC_BREAK) || (r_dec == DEC_EXT_BREAK)) begin
                        case (w_byte)
                            SC_UP:    w_up    = 1'b1;
                            SC_DOWN:  w_down  = 1'b1;
                            SC_LEFT:  w_left  = 1'b1;
                            SC_RIGHT: w_right = 1'b1;
                            SC_ENTER: w_enter = (r_dec == DEC_BREAK);
                            default:  w_enter = 1'b0;
                        endcase
                    end
                end
            endcase
        end
    end

    // While a selection is pending everything is frozen; this also drops a
    // release that lands in the same cycle the acknowledge is taken.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_x   <= '0;
            r_y   <= '0;
            r_sel <= 1'b0;
        end else if (r_sel) begin
            if (sel_ack) begin
                r_sel <= 1'b0;
            end
        end else begin
            if (w_up) begin
                r_y <= f_dec(r_y);
            end
            if (w_down) begin
                r_y <= f_inc(r_y);
            end
            if (w_left) begin
                r_x <= f_dec(r_x);
            end
            if (w_right) begin
                r_x <= f_inc(r_x);
            end
            if (w_enter) begin
                r_sel <= 1'b1;
            end
        end
    end

    assign x_input   = r_x;
    assign y_input   = r_y;
    assign sel_valid = r_sel;
    assign frame_err = w_frame_err;

endmodule
`default_nettype wire

// File: doc/ps2_cursor_decoder.md
PS2_CURSOR_DECODER -- requirements
Module: ps2_cursor_decoder

Interface
REQ-001 SHALL have parameter DIM, default 32, board side in cells; legal range 2..32.
REQ-002 SHALL have parameter FILTER_LEN, default 8, consecutive equal samples needed to accept a ps2_clk level.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, maximum clk cycles between frame bits.
REQ-004 SHALL have port clk  input  1  system clock (50 MHz); all logic on posedge clk.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
REQ-007 SHALL have port ps2_dat  input  1  raw PS/2 data from the keyboard, asynchronous.
REQ-008 SHALL have port sel_ack  input  1  consumer accepts the pending selection.
REQ-009 SHALL have port x_input  output  5  cursor column.
REQ-010 SHALL have port y_input  output  5  cursor row.
REQ-011 SHALL have port sel_valid  output  1  selection pending at (x_input, y_input).
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse when a frame is discarded.

Function
REQ-013 SHALL pass ps2_clk and ps2_dat through 2-flop synchronizers before any other use.
REQ-014 SHALL register a filtered falling edge when synchronized ps2_clk goes from filtered-high to low and then stays low for FILTER_LEN samples.
REQ-015 SHALL run the frame FSM IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE, sampling ps2_dat once per filtered falling edge.
REQ-016 SHALL stay in IDLE if the start bit samples 1; no frame_err is raised.
REQ-017 SHALL discard the byte, pulse frame_err, and return to IDLE when parity is not odd or the stop bit is 0.
REQ-018 SHALL abort to IDLE and pulse frame_err when, in DATA, PARITY or STOP, TIMEOUT_CYCLES cycles pass without a filtered falling edge.
REQ-019 SHALL present a good byte one cycle after the edge that sampled the stop bit (cycle E+1); any cursor or sel_valid change SHALL be visible at E+2.
REQ-020 SHALL run the decode FSM NORMAL, EXT (after 0xE0), BREAK (after 0xF0), EXT_BREAK (0xE0 then 0xF0); any other byte returns it to NORMAL.
REQ-021 SHALL act only on key release: 0x75 up (y-1), 0x72 down (y+1), 0x6B left (x-1), 0x74 right (x+1), with or without the 0xE0 prefix; 0x5A (no prefix) sets sel_valid.
REQ-022 SHALL ignore make codes, typematic repeats and unlisted codes.
REQ-023 SHALL return the decode FSM to NORMAL on frame_err.
REQ-024 SHALL, while sel_valid is 1, hold x_input/y_input frozen and ignore arrow and Enter releases.
REQ-025 SHALL clear sel_valid on the cycle after sel_ack is sampled high; sel_ack while sel_valid=0 has no effect.
REQ-026 SHALL drop a release that decodes in the same cycle sel_ack is accepted.
REQ-027 SHALL keep coordinates in 0..DIM-1 at all times.

Reset
REQ-028 SHALL, with reset low at a clk edge, set x_input=0, y_input=0, sel_valid=0, frame_err=0, both FSMs to IDLE/NORMAL, and the timeout and filter counters to 0.
REQ-029 SHALL discard any partially received frame on reset, including reset mid-frame, without raising frame_err.

Configuration
REQ-030 SHALL, with CURSOR_WRAP_EN defined, move coordinates modulo DIM (0 minus 1 gives DIM-1; DIM-1 plus 1 gives 0).
REQ-031 SHALL, without CURSOR_WRAP_EN, saturate coordinates at 0 and DIM-1.

Structure
REQ-032 SHALL take the scancode constants (SC_EXT 0xE0, SC_BREAK 0xF0, SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT, SC_ENTER) and the frame/decode state encodings from shared package lightsout_pkg.
REQ-033 SHALL place the synchronizer, filter, frame FSM and timeout in sub-module ps2_frame_rx; scancode decoding, the cursor and the handshake stay in the top module.

Verification
REQ-034 SHALL check: after reset, frames E0,F0,74 -> x_input 0->1 at E+2; y_input stays 0; frame_err stays 0.
REQ-035 SHALL check: byte 0x72 sent with even parity -> frame_err pulses for 1 cycle; then F0,72 -> y_input becomes 1.
REQ-036 SHALL check: x=0, release left -> x=0 without the macro and x=31 with CURSOR_WRAP_EN (DIM=32).
REQ-037 SHALL check: F0,5A -> sel_valid=1; F0,74 while pending -> x unchanged; sel_ack for 1 cycle -> sel_valid=0 on the next cycle.
REQ-038 SHALL check: stop after 4 data bits for 60000 cycles -> frame_err pulses once, then a full F0,75 frame decodes normally.
REQ-039 SHALL check: reset asserted mid-frame, then a new frame -> no frame_err and outputs at reset values until the new frame decodes.
